// File: rtl/legv8_ctrl_pkg.sv
// legv8_ctrl_pkg: shared types and constants for the LEGv8 multicycle control sequencer
//   state_t   : sequencer states
//   iclass_t  : decoded instruction class
//   OP_*      : opcode field encodings, ALUOP_* : ALU operation codes, SEL_* : mux selects
package legv8_ctrl_pkg;
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
    typedef enum logic [2:0] {CLS_R, CLS_LDUR, CLS_STUR, CLS_CBZ, CLS_B, CLS_ILL} iclass_t;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [5:0]  OP_B    = 6'b000101;
    localparam logic [1:0]  ALUOP_ADD   = 2'b00;
    localparam logic [1:0]  ALUOP_PASSB = 2'b01;
    localparam logic [1:0]  ALUOP_RTYPE = 2'b10;
    localparam logic [1:0]  SEL_RM  = 2'd0;
    localparam logic [1:0]  SEL_RT  = 2'd1;
    localparam logic [1:0]  SEL_REG = 2'd0;
    localparam logic [1:0]  SEL_IMM = 2'd1;
    localparam logic [1:0]  SEL_ALU = 2'd0;
    localparam logic [1:0]  SEL_MEM = 2'd1;
endpackage

// File: rtl/legv8_opcode_decode.sv
// legv8_opcode_decode: classifies IR[31:21] into an instruction class
//   opcode  in  : IR[31:21]
//   cls     out : instruction class
//   illegal out : encoding not recognised
import legv8_ctrl_pkg::*;

module legv8_opcode_decode (
    input  logic [10:0] opcode,
    output iclass_t     cls,
    output logic        illegal
);
    // CBZ and B are identified by their shorter prefixes inside the same 11-bit field
    always_comb begin
        cls = (opcode == OP_ADD || opcode == OP_SUB || opcode == OP_AND || opcode == OP_ORR) ? CLS_R :
              opcode == OP_LDUR      ? CLS_LDUR :
              opcode == OP_STUR      ? CLS_STUR :
              opcode[10:3] == OP_CBZ ? CLS_CBZ  :
              opcode[10:5] == OP_B   ? CLS_B    : CLS_ILL;
        illegal = cls == CLS_ILL;
    end
endmodule

// File: rtl/legv8_multicycle_control.sv
// legv8_multicycle_control: multicycle LEGv8 fetch/decode/control sequencer owning the PC
//   Clock, Reset_n (async, active-low)
//   InstrReq/InstrAddr/InstrValid/InstrData : instruction fetch handshake
//   Zero                                     : ALU zero flag, sampled for CBZ in EXEC
//   Read1, Rm, Rt, WriteReg, OpcodeField, SEin : instruction fields (combinational from IR)
//   Reg2Loc, ALUSrc, MemtoReg, ALUOp, RegWrite, MemRead, MemWrite : datapath controls
//   Halted      : sticky, set on illegal opcode until reset
//   RetiredCount: instructions retired, present only when PERF_COUNT_EN is defined
import legv8_ctrl_pkg::*;

module legv8_multicycle_control #(
    parameter int                    ADDR_WIDTH = 64,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    output logic                  InstrReq,
    output logic [ADDR_WIDTH-1:0] InstrAddr,
    input  logic                  InstrValid,
    input  logic [31:0]           InstrData,
    input  logic                  Zero,
    output logic [4:0]            Read1,
    output logic [4:0]            Rm,
    output logic [4:0]            Rt,
    output logic [4:0]            WriteReg,
    output logic [10:0]           OpcodeField,
    output logic [8:0]            SEin,
    output logic [1:0]            Reg2Loc,
    output logic [1:0]            ALUSrc,
    output logic [1:0]            MemtoReg,
    output logic [1:0]            ALUOp,
    output logic                  RegWrite,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic                  Halted
`ifdef PERF_COUNT_EN
    ,
    output logic [31:0]           RetiredCount
`endif
);
    state_t                state, state_nxt;
    iclass_t               cls;
    logic                  illegal, ls, in_x;
    logic [31:0]           ir;
    logic [ADDR_WIDTH-1:0] pc, pc_nxt, cbz_off, b_off;

    legv8_opcode_decode u_dec (.opcode(ir[31:21]), .cls(cls), .illegal(illegal));

    // Word offsets, sign-extended to the PC width and scaled by 4
    assign cbz_off = {{(ADDR_WIDTH-21){ir[23]}}, ir[23:5], 2'b00};
    assign b_off   = {{(ADDR_WIDTH-28){ir[25]}}, ir[25:0], 2'b00};

    always_comb begin
        ls          = cls == CLS_LDUR || cls == CLS_STUR;
        in_x        = state == EXEC || state == MEM || state == WB;
        InstrReq    = state == FETCH;
        InstrAddr   = pc;
        Read1       = ir[9:5];
        Rm          = ir[20:16];
        Rt          = ir[4:0];
        WriteReg    = ir[4:0];
        OpcodeField = ir[31:21];
        SEin        = ir[20:12];
        Reg2Loc     = (in_x && (ls || cls == CLS_CBZ)) ? SEL_RT : SEL_RM;
        ALUSrc      = (in_x && ls) ? SEL_IMM : SEL_REG;
        ALUOp       = !in_x ? 2'b00 : cls == CLS_R ? ALUOP_RTYPE : cls == CLS_CBZ ? ALUOP_PASSB : ALUOP_ADD;
        MemtoReg    = (state == WB && cls == CLS_LDUR) ? SEL_MEM : SEL_ALU;
        RegWrite    = state == WB;
        MemRead     = state == MEM && cls == CLS_LDUR;
        MemWrite    = state == MEM && cls == CLS_STUR;
        Halted      = state == HALT;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = FETCH;
            FETCH:   state_nxt = InstrValid ? DECODE : FETCH;
            DECODE:  state_nxt = illegal ? HALT : EXEC;
            EXEC:    state_nxt = cls == CLS_R ? WB : ls ? MEM : FETCH;
            MEM:     state_nxt = cls == CLS_LDUR ? WB : FETCH;
            WB:      state_nxt = FETCH;
            default: state_nxt = HALT;
        endcase
        pc_nxt = (state == EXEC && cls == CLS_CBZ) ? (Zero ? pc + cbz_off : pc + ADDR_WIDTH'(4)) :
                 (state == EXEC && cls == CLS_B)   ? pc + b_off :
                 ((state == MEM && cls == CLS_STUR) || state == WB) ? pc + ADDR_WIDTH'(4) : pc;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            pc    <= RESET_PC;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (state == FETCH && InstrValid) ir <= InstrData;
        end
    end

`ifdef PERF_COUNT_EN
    logic retire;
    assign retire = state == WB || (state == MEM && cls == CLS_STUR) ||
                    (state == EXEC && (cls == CLS_CBZ || cls == CLS_B));

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) RetiredCount <= '0;
        else if (retire) RetiredCount <= RetiredCount + 32'd1;
    end
`endif
endmodule

// File: tb/tb_legv8_multicycle_control.sv
// tb_legv8_multicycle_control: directed self-checking bench for legv8_multicycle_control
module tb_legv8_multicycle_control;
    logic        Clock = 1'b0, Reset_n = 1'b0, InstrValid = 1'b0, Zero = 1'b0;
    logic [31:0] InstrData = '0;
    logic        InstrReq, RegWrite, MemRead, MemWrite, Halted;
    logic [63:0] InstrAddr;
    logic [4:0]  Read1, Rm, Rt, WriteReg;
    logic [10:0] OpcodeField;
    logic [8:0]  SEin;
    logic [1:0]  Reg2Loc, ALUSrc, MemtoReg, ALUOp;
`ifdef PERF_COUNT_EN
    logic [31:0] RetiredCount;
`endif
    int n_cmp = 0, n_err = 0;

    legv8_multicycle_control dut (
        .Clock(Clock), .Reset_n(Reset_n), .InstrReq(InstrReq), .InstrAddr(InstrAddr),
        .InstrValid(InstrValid), .InstrData(InstrData), .Zero(Zero), .Read1(Read1), .Rm(Rm),
        .Rt(Rt), .WriteReg(WriteReg), .OpcodeField(OpcodeField), .SEin(SEin), .Reg2Loc(Reg2Loc),
        .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .ALUOp(ALUOp), .RegWrite(RegWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .Halted(Halted)
`ifdef PERF_COUNT_EN
        , .RetiredCount(RetiredCount)
`endif
    );

    always #5 Clock = ~Clock;

    task automatic step;
        @(negedge Clock);
    endtask

    // Presents one instruction for a single fetch edge, leaving the bench in DECODE
    task automatic fetch(input logic [31:0] instr);
        InstrValid = 1'b1;
        InstrData  = instr;
        step();
        InstrValid = 1'b0;
    endtask

    task automatic test_reset;
        step();
        step();
        n_cmp++; if (InstrReq !== 1'b0) begin n_err++; $display("FAIL reset_req: got %0d exp 0", InstrReq); end
        n_cmp++; if (InstrAddr !== 64'h0) begin n_err++; $display("FAIL reset_pc: got %0h exp 0", InstrAddr); end
        n_cmp++; if (Halted !== 1'b0) begin n_err++; $display("FAIL reset_halted: got %0d exp 0", Halted); end
        n_cmp++; if ({RegWrite, MemRead, MemWrite, ALUOp, Reg2Loc, ALUSrc, MemtoReg} !== 11'h0) begin n_err++; $display("FAIL reset_ctrl: got %0h exp 0", {RegWrite, MemRead, MemWrite, ALUOp, Reg2Loc, ALUSrc, MemtoReg}); end
        n_cmp++; if (OpcodeField !== 11'h0) begin n_err++; $display("FAIL reset_ir: got %0h exp 0", OpcodeField); end
`ifdef PERF_COUNT_EN
        n_cmp++; if (RetiredCount !== 32'd0) begin n_err++; $display("FAIL reset_count: got %0d exp 0", RetiredCount); end
`endif
        Reset_n = 1'b1;
        #1;
        n_cmp++; if (InstrReq !== 1'b0) begin n_err++; $display("FAIL idle_req: got %0d exp 0", InstrReq); end
        step();
        n_cmp++; if (InstrReq !== 1'b1 || InstrAddr !== 64'h0) begin n_err++; $display("FAIL first_fetch: got req %0d addr %0h exp 1 0", InstrReq, InstrAddr); end
    endtask

    task automatic test_add(input logic [63:0] pc, input int cnt);
        n_cmp++; if (InstrReq !== 1'b1 || InstrAddr !== pc) begin n_err++; $display("FAIL add_fetch: got req %0d addr %0h exp 1 %0h", InstrReq, InstrAddr, pc); end
        fetch(32'h8B020023);
        n_cmp++; if (InstrReq !== 1'b0 || OpcodeField !== 11'h458 || ALUOp !== 2'd0 || RegWrite !== 1'b0) begin n_err++; $display("FAIL add_decode: got req %0d op %0h aluop %0d rw %0d exp 0 458 0 0", InstrReq, OpcodeField, ALUOp, RegWrite); end
        step();
        n_cmp++; if (ALUOp !== 2'b10 || Reg2Loc !== 2'd0 || ALUSrc !== 2'd0 || RegWrite !== 1'b0) begin n_err++; $display("FAIL add_exec: got aluop %0d r2l %0d src %0d rw %0d exp 2 0 0 0", ALUOp, Reg2Loc, ALUSrc, RegWrite); end
        step();
        n_cmp++; if (RegWrite !== 1'b1 || WriteReg !== 5'd3 || Read1 !== 5'd1 || Rm !== 5'd2 || MemtoReg !== 2'd0 || ALUOp !== 2'b10) begin n_err++; $display("FAIL add_wb: got rw %0d wr %0d rn %0d rm %0d m2r %0d aluop %0d exp 1 3 1 2 0 2", RegWrite, WriteReg, Read1, Rm, MemtoReg, ALUOp); end
        step();
        n_cmp++; if (RegWrite !== 1'b0 || InstrReq !== 1'b1 || InstrAddr !== pc + 64'd4) begin n_err++; $display("FAIL add_done: got rw %0d req %0d addr %0h exp 0 1 %0h", RegWrite, InstrReq, InstrAddr, pc + 64'd4); end
`ifdef PERF_COUNT_EN
        n_cmp++; if (RetiredCount !== cnt) begin n_err++; $display("FAIL add_count: got %0d exp %0d", RetiredCount, cnt); end
`endif
    endtask

    task automatic test_ldur;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (InstrReq !== 1'b1 || InstrAddr !== 64'h4) begin n_err++; $display("FAIL ldur_wait%0d: got req %0d addr %0h exp 1 4", i, InstrReq, InstrAddr); end
            step();
        end
        n_cmp++; if (InstrReq !== 1'b1 || InstrAddr !== 64'h4) begin n_err++; $display("FAIL ldur_fetch: got req %0d addr %0h exp 1 4", InstrReq, InstrAddr); end
        fetch(32'hF8408045);
        step();
        n_cmp++; if (ALUSrc !== 2'd1 || Reg2Loc !== 2'd1 || ALUOp !== 2'b00 || MemRead !== 1'b0) begin n_err++; $display("FAIL ldur_exec: got src %0d r2l %0d aluop %0d mr %0d exp 1 1 0 0", ALUSrc, Reg2Loc, ALUOp, MemRead); end
        step();
        n_cmp++; if (MemRead !== 1'b1 || SEin !== 9'd8 || ALUSrc !== 2'd1 || RegWrite !== 1'b0 || Rt !== 5'd5) begin n_err++; $display("FAIL ldur_mem: got mr %0d sein %0d src %0d rw %0d rt %0d exp 1 8 1 0 5", MemRead, SEin, ALUSrc, RegWrite, Rt); end
        step();
        n_cmp++; if (MemtoReg !== 2'd1 || RegWrite !== 1'b1 || MemRead !== 1'b0) begin n_err++; $display("FAIL ldur_wb: got m2r %0d rw %0d mr %0d exp 1 1 0", MemtoReg, RegWrite, MemRead); end
        step();
        n_cmp++; if (InstrAddr !== 64'h8 || RegWrite !== 1'b0 || MemtoReg !== 2'd0) begin n_err++; $display("FAIL ldur_done: got addr %0h rw %0d m2r %0d exp 8 0 0", InstrAddr, RegWrite, MemtoReg); end
    endtask

    // InstrValid is left high with garbage data after the fetch; IR must not change
    task automatic test_stur;
        fetch(32'hF8000045);
        InstrValid = 1'b1;
        InstrData  = 32'hFFFFFFFF;
        step();
        n_cmp++; if (Reg2Loc !== 2'd1 || MemWrite !== 1'b0 || RegWrite !== 1'b0 || OpcodeField !== 11'h7C0) begin n_err++; $display("FAIL stur_exec: got r2l %0d mw %0d rw %0d op %0h exp 1 0 0 7c0", Reg2Loc, MemWrite, RegWrite, OpcodeField); end
        step();
        InstrValid = 1'b0;
        n_cmp++; if (MemWrite !== 1'b1 || RegWrite !== 1'b0 || MemRead !== 1'b0 || OpcodeField !== 11'h7C0) begin n_err++; $display("FAIL stur_mem: got mw %0d rw %0d mr %0d op %0h exp 1 0 0 7c0", MemWrite, RegWrite, MemRead, OpcodeField); end
        step();
        n_cmp++; if (MemWrite !== 1'b0 || RegWrite !== 1'b0 || InstrReq !== 1'b1 || InstrAddr !== 64'hC) begin n_err++; $display("FAIL stur_done: got mw %0d rw %0d req %0d addr %0h exp 0 0 1 c", MemWrite, RegWrite, InstrReq, InstrAddr); end
`ifdef PERF_COUNT_EN
        n_cmp++; if (RetiredCount !== 32'd3) begin n_err++; $display("FAIL stur_count: got %0d exp 3", RetiredCount); end
`endif
    endtask

    task automatic test_cbz(input logic z, input logic [63:0] pc, input logic [63:0] exp_pc, input int cnt);
        n_cmp++; if (InstrAddr !== pc) begin n_err++; $display("FAIL cbz_start: got %0h exp %0h", InstrAddr, pc); end
        fetch(32'hB4000064);
        step();
        Zero = z;
        n_cmp++; if (ALUOp !== 2'b01 || Reg2Loc !== 2'd1 || ALUSrc !== 2'd0 || Rt !== 5'd4 || RegWrite !== 1'b0) begin n_err++; $display("FAIL cbz_exec: got aluop %0d r2l %0d src %0d rt %0d rw %0d exp 1 1 0 4 0", ALUOp, Reg2Loc, ALUSrc, Rt, RegWrite); end
        step();
        Zero = 1'b0;
        n_cmp++; if (InstrReq !== 1'b1 || InstrAddr !== exp_pc || ALUOp !== 2'd0 || Reg2Loc !== 2'd0) begin n_err++; $display("FAIL cbz_z%0d_pc: got req %0d addr %0h aluop %0d r2l %0d exp 1 %0h 0 0", z, InstrReq, InstrAddr, ALUOp, Reg2Loc, exp_pc); end
`ifdef PERF_COUNT_EN
        n_cmp++; if (RetiredCount !== cnt) begin n_err++; $display("FAIL cbz_count: got %0d exp %0d", RetiredCount, cnt); end
`endif
    endtask

    task automatic test_b;
        fetch(32'h17FFFFFE);
        step();
        n_cmp++; if (ALUOp !== 2'd0 || Reg2Loc !== 2'd0 || ALUSrc !== 2'd0 || RegWrite !== 1'b0 || MemWrite !== 1'b0) begin n_err++; $display("FAIL b_exec: got aluop %0d r2l %0d src %0d rw %0d mw %0d exp 0 0 0 0 0", ALUOp, Reg2Loc, ALUSrc, RegWrite, MemWrite); end
        step();
        n_cmp++; if (InstrReq !== 1'b1 || InstrAddr !== 64'h18) begin n_err++; $display("FAIL b_pc: got req %0d addr %0h exp 1 18", InstrReq, InstrAddr); end
`ifdef PERF_COUNT_EN
        n_cmp++; if (RetiredCount !== 32'd7) begin n_err++; $display("FAIL b_count: got %0d exp 7", RetiredCount); end
`endif
    endtask

    task automatic test_illegal;
        fetch(32'hFFFFFFFF);
        n_cmp++; if (Halted !== 1'b0) begin n_err++; $display("FAIL ill_decode: got %0d exp 0", Halted); end
        step();
        n_cmp++; if (Halted !== 1'b1 || InstrReq !== 1'b0 || InstrAddr !== 64'h18) begin n_err++; $display("FAIL ill_halt: got halted %0d req %0d addr %0h exp 1 0 18", Halted, InstrReq, InstrAddr); end
        InstrValid = 1'b1;
        InstrData  = 32'h8B020023;
        step();
        step();
        InstrValid = 1'b0;
        n_cmp++; if (Halted !== 1'b1 || InstrReq !== 1'b0 || InstrAddr !== 64'h18 || RegWrite !== 1'b0 || ALUOp !== 2'd0) begin n_err++; $display("FAIL ill_sticky: got halted %0d req %0d addr %0h rw %0d aluop %0d exp 1 0 18 0 0", Halted, InstrReq, InstrAddr, RegWrite, ALUOp); end
`ifdef PERF_COUNT_EN
        n_cmp++; if (RetiredCount !== 32'd7) begin n_err++; $display("FAIL ill_count: got %0d exp 7", RetiredCount); end
`endif
        Reset_n = 1'b0;
        #1;
        n_cmp++; if (Halted !== 1'b0 || InstrAddr !== 64'h0) begin n_err++; $display("FAIL ill_reset: got halted %0d addr %0h exp 0 0", Halted, InstrAddr); end
        step();
        Reset_n = 1'b1;
        step();
        n_cmp++; if (InstrReq !== 1'b1 || InstrAddr !== 64'h0) begin n_err++; $display("FAIL ill_restart: got req %0d addr %0h exp 1 0", InstrReq, InstrAddr); end
    endtask

    task automatic test_reset_mid;
        test_add(64'h0, 1);
        fetch(32'hF8000045);
        step();
        step();
        n_cmp++; if (MemWrite !== 1'b1 || InstrAddr !== 64'h4) begin n_err++; $display("FAIL mid_mem: got mw %0d addr %0h exp 1 4", MemWrite, InstrAddr); end
        #2;
        Reset_n = 1'b0;
        #1;
        n_cmp++; if (MemWrite !== 1'b0 || InstrReq !== 1'b0 || InstrAddr !== 64'h0) begin n_err++; $display("FAIL mid_abort: got mw %0d req %0d addr %0h exp 0 0 0", MemWrite, InstrReq, InstrAddr); end
`ifdef PERF_COUNT_EN
        n_cmp++; if (RetiredCount !== 32'd0) begin n_err++; $display("FAIL mid_count: got %0d exp 0", RetiredCount); end
`endif
        step();
        Reset_n = 1'b1;
        #1;
        n_cmp++; if (InstrReq !== 1'b0 || MemWrite !== 1'b0) begin n_err++; $display("FAIL mid_idle: got req %0d mw %0d exp 0 0", InstrReq, MemWrite); end
        step();
        n_cmp++; if (InstrReq !== 1'b1 || InstrAddr !== 64'h0 || MemWrite !== 1'b0) begin n_err++; $display("FAIL mid_fetch: got req %0d addr %0h mw %0d exp 1 0 0", InstrReq, InstrAddr, MemWrite); end
    endtask

    initial begin
        test_reset();
        test_add(64'h0, 1);
        test_ldur();
        test_stur();
        test_add(64'hC, 4);
        test_cbz(1'b1, 64'h10, 64'h1C, 5);
        test_cbz(1'b0, 64'h1C, 64'h20, 6);
        test_b();
        test_illegal();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
